// File: rtl/gb_pkg.sv
// Shared pixel-path definitions: pixel width and the {sof, pix} entry layout
// stored by the pixel FIFO between upscalar and lcddrv.
package gb_pkg;

  localparam int PIX_W   = 16;
  localparam int ENTRY_W = 17;
  localparam int SOF_BIT = 16;

  typedef logic [ENTRY_W-1:0] entry_t;

  function automatic entry_t make_entry(input logic sof, input logic [PIX_W-1:0] pix);
    entry_t e;
    e = '0;
    e[SOF_BIT] = sof;
    e[PIX_W-1:0] = pix;
    return e;
  endfunction

endpackage

// File: rtl/pix_fifo_ram.sv
// Simple dual-port storage for the pixel FIFO: synchronous write, asynchronous
// read so it maps onto distributed RAM.
module pix_fifo_ram
  import gb_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  entry_t        wdata,
  input  logic [AW-1:0] raddr,
  output entry_t        rdata
);

  entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pix_fifo.sv
// Elastic first-word-fall-through pixel buffer with start-of-frame tagging and
// sticky overflow. Define PIX_FIFO_FLUSH_ON_FRAME_EN to make in_frame flush the queue.
module pix_fifo
  import gb_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int AW     = 6,
  parameter int AF_LVL = 56
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [PIX_W-1:0]  in_pix,
  input  logic              in_frame,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PIX_W-1:0]  out_pix,
  output logic              out_sof,
  output logic [AW:0]       level,
  output logic              almost_full,
  output logic              overflow
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_THR   = (AW+1)'(AF_LVL);

  logic [AW-1:0] wptr, rptr, rptr_base, rptr_n, wptr_n;
  logic [AW:0]   level_base, level_n;
  logic          sof_pend, flush, full, pop, wr_acc;
  entry_t        wr_entry, rd_entry, head_n;

`ifdef PIX_FIFO_FLUSH_ON_FRAME_EN
  assign flush = in_frame;
`else
  assign flush = 1'b0;
`endif

  // A flush behaves as if the queue were already empty this cycle, so a
  // same-cycle pixel becomes the first entry of the new frame.
  always_comb begin
    rptr_base  = flush ? wptr : rptr;
    level_base = flush ? '0 : level;
    full       = (level_base == FULL_LVL);
    pop        = out_valid & out_ready & ~flush;
    wr_acc     = in_valid & (~full | pop);
    wr_entry   = make_entry(in_frame | sof_pend, in_pix);
    rptr_n     = pop ? rptr_base + AW'(1) : rptr_base;
    wptr_n     = wr_acc ? wptr + AW'(1) : wptr;
    level_n    = level_base;
    if (wr_acc && !pop)      level_n = level_base + (AW+1)'(1);
    else if (!wr_acc && pop) level_n = level_base - (AW+1)'(1);
    // RAM write lands on this edge, so a new head equal to the write slot bypasses it.
    head_n = (wr_acc && (rptr_n == wptr)) ? wr_entry : rd_entry;
  end

  pix_fifo_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wptr),
    .wdata (wr_entry),
    .raddr (rptr_n),
    .rdata (rd_entry)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr        <= '0;
      rptr        <= '0;
      level       <= '0;
      sof_pend    <= 1'b0;
      overflow    <= 1'b0;
      almost_full <= 1'b0;
      out_valid   <= 1'b0;
      out_pix     <= '0;
      out_sof     <= 1'b0;
    end else begin
      wptr        <= wptr_n;
      rptr        <= rptr_n;
      level       <= level_n;
      sof_pend    <= (in_frame | sof_pend) & ~wr_acc;
      overflow    <= (overflow & ~flush) | (in_valid & ~wr_acc);
      almost_full <= (level_n >= AF_THR);
      out_valid   <= (level_n != '0);
      if (level_n != '0) begin
        out_pix <= head_n[PIX_W-1:0];
        out_sof <= head_n[SOF_BIT];
      end
    end
  end

endmodule

// File: tb/tb_pix_fifo.sv
// Randomized self-checking bench for pix_fifo against a queue-based reference
// model; honours PIX_FIFO_FLUSH_ON_FRAME_EN the same way the design does.
module tb_pix_fifo;

  localparam int DEPTH  = 64;
  localparam int AF_LVL = 56;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_pix = '0;
  logic        in_frame = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [15:0] out_pix;
  logic        out_sof;
  logic [6:0]  level;
  logic        almost_full;
  logic        overflow;

  int vectors = 0;
  int miscompares = 0;

  logic [16:0] mq[$];
  logic        m_pend = 1'b0;
  logic        m_ovf = 1'b0;

  always #5 clk = ~clk;

  pix_fifo #(.DEPTH(DEPTH), .AW(6), .AF_LVL(AF_LVL)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_pix      (in_pix),
    .in_frame    (in_frame),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pix     (out_pix),
    .out_sof     (out_sof),
    .level       (level),
    .almost_full (almost_full),
    .overflow    (overflow)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compareAll();
    checkOutput("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    checkOutput("level", 32'(level), 32'(mq.size()));
    checkOutput("almost_full", 32'(almost_full), 32'(mq.size() >= AF_LVL));
    checkOutput("overflow", 32'(overflow), 32'(m_ovf));
    if (mq.size() != 0) begin
      checkOutput("out_pix", 32'(out_pix), 32'(mq[0][15:0]));
      checkOutput("out_sof", 32'(out_sof), 32'(mq[0][16]));
    end
  endtask

  // Reference: a plain queue of {sof, pix}; the head is visible one edge after it arrives.
  task automatic modelStep(input logic iv, input logic [15:0] p, input logic fr, input logic rdy);
    logic flush_now, pop, acc;
    flush_now = 1'b0;
`ifdef PIX_FIFO_FLUSH_ON_FRAME_EN
    flush_now = fr;
`endif
    if (flush_now) begin
      mq.delete();
      m_ovf = 1'b0;
    end
    pop = !flush_now && (mq.size() > 0) && rdy;
    acc = iv && ((mq.size() < DEPTH) || pop);
    if (pop) void'(mq.pop_front());
    if (acc) mq.push_back({fr | m_pend, p});
    m_pend = (fr | m_pend) & ~acc;
    if (iv && !acc) m_ovf = 1'b1;
  endtask

  task automatic applyStimulus(input logic iv, input logic [15:0] p, input logic fr, input logic rdy);
    in_valid  = iv;
    in_pix    = p;
    in_frame  = fr;
    out_ready = rdy;
    modelStep(iv, p, fr, rdy);
    @(posedge clk);
    #1;
    compareAll();
  endtask

  task automatic doReset();
    in_valid = 1'b0;
    in_frame = 1'b0;
    out_ready = 1'b0;
    reset = 1'b1;
    mq.delete();
    m_pend = 1'b0;
    m_ovf = 1'b0;
    #1;
    compareAll();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    compareAll();
  endtask

  initial begin
    #2;
    doReset();

    // Frame start followed by four pixels drained immediately
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 16'(i), 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);

    // Fill to capacity under backpressure, overflow once, drain
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1'b1, 16'(16'h1000 + i), 1'b0, 1'b0);
    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);

    // Full FIFO with simultaneous write and pop
    doReset();
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 16'(16'h2000 + i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 16'(16'h3000 + i), 1'b0, 1'b1);
    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);

    // Random traffic and backpressure, with an asynchronous reset part way through
    for (int i = 0; i < 1200; i++) begin
      if (i == 700) doReset();
      applyStimulus(1'($urandom_range(0, 99) < 55), 16'($urandom), 1'($urandom_range(0, 49) == 0),
                    1'($urandom_range(0, 99) < 60));
    end
    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);

    // in_frame with ten pixels queued, then one tagged pixel
    doReset();
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 16'(16'h4000 + i), 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h5A5A, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
